// File: rtl/reminder_scheduler.sv
// Multi-channel time-of-day reminder engine: seconds timebase, per-channel
// IDLE/ALERT/SNOOZE sequencers, LED/alarm outputs and a 1 PPS heartbeat.
module reminder_scheduler #(
  parameter int unsigned TICK_DIV      = 250000,
  parameter int unsigned SLOTS_PER_SEC = 200,
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned DAY_SEC       = 86400,
  parameter int unsigned SNOOZE_SEC    = 300,
  parameter int unsigned SEC_W         = 17
) (
  input  logic              clk_int,
  input  logic              rst_int,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic              cfg_en,
  input  logic [SEC_W-1:0]  cfg_sec,
  input  logic [NUM_CH-1:0] ack,
  input  logic              stop_sw,
  input  logic              snooze,
  output logic [SEC_W-1:0]  tod,
  output logic [NUM_CH-1:0] led,
  output logic              led_1pps,
  output logic              cube,
  output logic [3:0]        alarm_id
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SLOT_W = (SLOTS_PER_SEC > 1) ? $clog2(SLOTS_PER_SEC) : 1;
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_SEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALERT  = 2'd1,
    ST_SNOOZE = 2'd2
  } ch_state_e;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SEC_W-1:0]  tod_q, tod_d;
  logic              pps_q, pps_d;
  logic              slot_tick, sec_tick;

  ch_state_e         st_q  [NUM_CH];
  ch_state_e         st_d  [NUM_CH];
  logic [SNZ_W-1:0]  snz_q [NUM_CH];
  logic [SNZ_W-1:0]  snz_d [NUM_CH];
  logic [SEC_W-1:0]  tgt_q [NUM_CH];
  logic [SEC_W-1:0]  tgt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;

  logic [NUM_CH-1:0] led_q, led_d;
  logic              cube_q, cube_d;
  logic [3:0]        aid_q, aid_d;
  logic              aid_found;

  // Timebase: prescaler -> slot counter -> seconds of day and heartbeat
  always_comb begin
    slot_tick = (pre_q == PRE_W'(TICK_DIV - 1));
    sec_tick  = slot_tick && (slot_q == SLOT_W'(SLOTS_PER_SEC - 1));
    pre_d     = slot_tick ? '0 : pre_q + PRE_W'(1);
    slot_d    = slot_q;
    tod_d     = tod_q;
    pps_d     = pps_q;
    if (slot_tick) begin
      slot_d = (slot_q == SLOT_W'(SLOTS_PER_SEC - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
    if (sec_tick) begin
      tod_d = (tod_q == SEC_W'(DAY_SEC - 1)) ? '0 : tod_q + SEC_W'(1);
      pps_d = ~pps_q;
    end
  end

  // Channel sequencers; branch order encodes cfg > stop > ack > snooze > tick
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      snz_d[i] = snz_q[i];
      tgt_d[i] = tgt_q[i];
      en_d[i]  = en_q[i];
      if (cfg_we && (cfg_ch == 4'(i))) begin
        en_d[i]  = cfg_en;
        tgt_d[i] = cfg_sec;
        st_d[i]  = ST_IDLE;
      end else if (stop_sw || ack[i]) begin
        st_d[i] = ST_IDLE;
      end else if (snooze && (st_q[i] == ST_ALERT)) begin
        st_d[i]  = ST_SNOOZE;
        snz_d[i] = SNZ_W'(SNOOZE_SEC);
      end else if (sec_tick) begin
        case (st_q[i])
          // Match against the post-increment time so led rises with tod
          ST_IDLE: begin
            if (en_q[i] && (tgt_q[i] == tod_d)) begin
              st_d[i] = ST_ALERT;
            end
          end
          ST_SNOOZE: begin
            if (snz_q[i] == SNZ_W'(1)) begin
              st_d[i] = ST_ALERT;
            end else begin
              snz_d[i] = snz_q[i] - SNZ_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output decode from next state; cube follows the registered led
  always_comb begin
    aid_d     = '0;
    aid_found = 1'b0;
    cube_d    = |led_q;
    for (int i = 0; i < NUM_CH; i++) begin
      led_d[i] = (st_d[i] == ST_ALERT);
      if (!aid_found && led_d[i]) begin
        aid_d     = 4'(i);
        aid_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_int or negedge rst_int) begin
    if (!rst_int) begin
      pre_q  <= '0;
      slot_q <= '0;
      tod_q  <= '0;
      pps_q  <= 1'b0;
      en_q   <= '0;
      led_q  <= '0;
      cube_q <= 1'b0;
      aid_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= ST_IDLE;
        snz_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      tod_q  <= tod_d;
      pps_q  <= pps_d;
      en_q   <= en_d;
      led_q  <= led_d;
      cube_q <= cube_d;
      aid_q  <= aid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        snz_q[i] <= snz_d[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign tod      = tod_q;
  assign led      = led_q;
  assign led_1pps = pps_q;
  assign cube     = cube_q;
  assign alarm_id = aid_q;

endmodule

// File: tb/tb_reminder_scheduler.sv
// Scoreboard bench for reminder_scheduler: directed scenarios plus random traffic
// checked against a cycle-count based reference model.
module tb_reminder_scheduler;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned SPS        = 2;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned DAY_SEC    = 10;
  localparam int unsigned SNOOZE_SEC = 3;
  localparam int unsigned SEC_W      = 17;
  localparam int unsigned SEC_CYC    = TICK_DIV * SPS;
  localparam int unsigned DAY_CYC    = SEC_CYC * DAY_SEC;

  localparam int M_IDLE   = 0;
  localparam int M_ALERT  = 1;
  localparam int M_SNOOZE = 2;

  logic              clk_int = 1'b0;
  logic              rst_int = 1'b0;
  logic              cfg_we  = 1'b0;
  logic [3:0]        cfg_ch  = '0;
  logic              cfg_en  = 1'b0;
  logic [SEC_W-1:0]  cfg_sec = '0;
  logic [NUM_CH-1:0] ack     = '0;
  logic              stop_sw = 1'b0;
  logic              snooze  = 1'b0;
  logic [SEC_W-1:0]  tod;
  logic [NUM_CH-1:0] led;
  logic              led_1pps;
  logic              cube;
  logic [3:0]        alarm_id;

  reminder_scheduler #(
    .TICK_DIV(TICK_DIV), .SLOTS_PER_SEC(SPS), .NUM_CH(NUM_CH),
    .DAY_SEC(DAY_SEC), .SNOOZE_SEC(SNOOZE_SEC), .SEC_W(SEC_W)
  ) dut (
    .clk_int(clk_int), .rst_int(rst_int), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_sec(cfg_sec), .ack(ack), .stop_sw(stop_sw),
    .snooze(snooze), .tod(tod), .led(led), .led_1pps(led_1pps),
    .cube(cube), .alarm_id(alarm_id)
  );

  always #5 clk_int = ~clk_int;

  typedef struct {
    int tod;
    int led;
    int pps;
    int cube;
    int aid;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: time derives from edges since reset
  int   m_n;
  int   m_st  [NUM_CH];
  int   m_snz [NUM_CH];
  bit   m_en  [NUM_CH];
  int   m_tgt [NUM_CH];
  int   m_prev_led;
  exp_t last_e;
  bit   last_sec;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_prev_led = 0;
    last_sec = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_st[i] = M_IDLE; m_snz[i] = 0; m_en[i] = 1'b0; m_tgt[i] = 0;
    end
  endtask

  task automatic model_step(input bit we, input int ch, input bit en, input int sec_v,
                            input bit [NUM_CH-1:0] a, input bit st, input bit sn,
                            output exp_t e);
    bit sec;
    int tod_v;
    int led_v;
    m_n++;
    sec   = (m_n % SEC_CYC) == 0;
    tod_v = (m_n / SEC_CYC) % DAY_SEC;
    for (int i = 0; i < NUM_CH; i++) begin
      if (we && ch == i) begin
        m_en[i] = en; m_tgt[i] = sec_v; m_st[i] = M_IDLE;
      end else if (st || a[i]) begin
        m_st[i] = M_IDLE;
      end else if (sn && m_st[i] == M_ALERT) begin
        m_st[i] = M_SNOOZE; m_snz[i] = SNOOZE_SEC;
      end else if (sec) begin
        if (m_st[i] == M_IDLE && m_en[i] && m_tgt[i] == tod_v) m_st[i] = M_ALERT;
        else if (m_st[i] == M_SNOOZE) begin
          if (m_snz[i] == 1) m_st[i] = M_ALERT;
          else m_snz[i]--;
        end
      end
    end
    led_v = 0;
    e.aid = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m_st[i] == M_ALERT) begin
        led_v += (1 << i);
        e.aid = i;
      end
    end
    e.tod  = tod_v;
    e.led  = led_v;
    e.pps  = (m_n / SEC_CYC) % 2;
    e.cube = (m_prev_led != 0) ? 1 : 0;
    m_prev_led = led_v;
    last_sec = sec;
    last_e = e;
  endtask

  // One clock: drive on the falling edge, queue the model's post-edge outputs
  task automatic cyc(input bit we, input int ch, input bit en, input int sec_v,
                     input bit [NUM_CH-1:0] a, input bit st, input bit sn);
    exp_t e;
    @(negedge clk_int);
    cfg_we = we; cfg_ch = 4'(ch); cfg_en = en; cfg_sec = SEC_W'(sec_v);
    ack = a; stop_sw = st; snooze = sn;
    model_step(we, ch, en, sec_v, a, st, sn, e);
    sb_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk_int);
    #2;
  endtask

  task automatic run_until_tod(input int t);
    int k;
    k = 0;
    do begin
      idle();
      k++;
    end while (!(last_sec && last_e.tod == t) && k < int'(2 * DAY_CYC));
    if (!(last_sec && last_e.tod == t)) begin
      errors++;
      $display("FAIL wait_tod: timed out waiting for tod %0d", t);
    end
  endtask

  task automatic run_until_pre(input int t);
    int k;
    k = 0;
    while (!(((m_n + 1) % SEC_CYC) == 0 && (((m_n + 1) / SEC_CYC) % DAY_SEC) == t)
           && k < int'(2 * DAY_CYC)) begin
      idle();
      k++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_int);
    rst_int = 1'b0;
    cfg_we = 1'b0; ack = '0; stop_sw = 1'b0; snooze = 1'b0;
    #1;
    check("rst_tod", int'(tod), 0);
    check("rst_led", int'(led), 0);
    check("rst_cube", int'(cube), 0);
    check("rst_pps", int'(led_1pps), 0);
    check("rst_aid", int'(alarm_id), 0);
    sb_q.delete();
    model_reset();
    repeat (2) @(negedge clk_int);
    @(posedge clk_int);
    #3 rst_int = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_int);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("tod", int'(tod), e.tod);
        check("led", int'(led), e.led);
        check("led_1pps", int'(led_1pps), e.pps);
        check("cube", int'(cube), e.cube);
        check("alarm_id", int'(alarm_id), e.aid);
      end
    end
  end

  initial begin : stim
    bit [NUM_CH-1:0] a;
    model_reset();
    repeat (3) @(negedge clk_int);
    check("init_tod", int'(tod), 0);
    check("init_led", int'(led), 0);
    @(posedge clk_int);
    #3 rst_int = 1'b1;

    // Timebase: first second after 8 cycles, day wrap after 80
    repeat (SEC_CYC) idle();
    settle();
    check("t1_tod_1s", int'(tod), 1);
    check("t1_pps_1s", int'(led_1pps), 1);
    repeat (DAY_CYC - SEC_CYC) idle();
    settle();
    check("t1_tod_wrap", int'(tod), 0);
    check("t1_pps_wrap", int'(led_1pps), 0);

    // Single channel alert and acknowledge
    cyc(1'b1, 2, 1'b1, 3, '0, 1'b0, 1'b0);
    run_until_tod(3);
    settle();
    check("t2_led", int'(led), 4);
    check("t2_aid", int'(alarm_id), 2);
    idle();
    settle();
    check("t2_cube", int'(cube), 1);
    cyc(1'b0, 0, 1'b0, 0, 4'b0100, 1'b0, 1'b0);
    settle();
    check("t2_led_ack", int'(led), 0);
    idle();
    settle();
    check("t2_cube_ack", int'(cube), 0);
    cyc(1'b1, 2, 1'b0, 0, '0, 1'b0, 1'b0);

    // Two channels on the same second
    cyc(1'b1, 0, 1'b1, 5, '0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b1, 5, '0, 1'b0, 1'b0);
    run_until_tod(5);
    settle();
    check("t3_led", int'(led), 9);
    check("t3_aid", int'(alarm_id), 0);
    cyc(1'b0, 0, 1'b0, 0, 4'b0001, 1'b0, 1'b0);
    settle();
    check("t3_aid_ack", int'(alarm_id), 3);
    cyc(1'b1, 0, 1'b0, 0, '0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 0, '0, 1'b0, 1'b0);

    // Snooze re-alerts after three seconds; stop during snooze cancels it
    cyc(1'b1, 1, 1'b1, 2, '0, 1'b0, 1'b0);
    run_until_tod(2);
    settle();
    check("t4_led", int'(led), 2);
    cyc(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);
    settle();
    check("t4_led_snz", int'(led), 0);
    run_until_tod(5);
    settle();
    check("t4_realert", int'(led), 2);
    cyc(1'b0, 0, 1'b0, 0, 4'b0010, 1'b0, 1'b0);
    run_until_tod(2);
    cyc(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);
    run_until_tod(4);
    cyc(1'b0, 0, 1'b0, 0, '0, 1'b1, 1'b0);
    run_until_tod(5);
    settle();
    check("t4_stopped", int'(led), 0);

    // cfg write beats a simultaneous ack and match; new target then fires
    cyc(1'b1, 1, 1'b1, 7, '0, 1'b0, 1'b0);
    run_until_pre(7);
    cyc(1'b1, 1, 1'b1, 9, 4'b0010, 1'b0, 1'b0);
    settle();
    check("t5_cfg_wins", int'(led), 0);
    run_until_tod(9);
    settle();
    check("t5_new_tgt", int'(led), 2);
    check("t5_aid", int'(alarm_id), 1);
    cyc(1'b1, 7, 1'b0, 0, '0, 1'b0, 1'b0);
    settle();
    check("t5_bad_ch", int'(led), 2);
    idle();

    // Asynchronous reset in the middle of an alert
    reset_dut();
    repeat (DAY_CYC + 4) idle();

    // Random traffic, with a reset partway through
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 700; n++) begin
        a = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom_range(0, 15)) : '0;
        cyc($urandom_range(0, 99) < 8, int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 11)), a,
            $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
      end
      if (pass == 0) reset_dut();
    end

    idle();
    settle();
    check("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reminder_scheduler.md
Name: reminder_scheduler

Overview:
- Parametrised multi-channel reminder engine. Runs a time-of-day seconds counter from the DCM-derived clock.
- Each of NUM_CH channels fires an alert at a programmable second of day. Alerts can be acknowledged or snoozed.
- Drives channel LEDs, a 1 PPS heartbeat and a shared alarm (cube/buzzer) output.
- Sits directly behind the clock/reset generation block; replaces fixed hard-coded reminder slots with runtime-configurable channels.

Parameters:
- TICK_DIV, 250000, clk_int cycles per slot tick (5 ms at 50 MHz).
- SLOTS_PER_SEC, 200, slot ticks per second.
- NUM_CH, 8, number of reminder channels (1..16).
- DAY_SEC, 86400, seconds per day; time-of-day wraps at DAY_SEC-1.
- SNOOZE_SEC, 300, snooze duration in seconds.
- SEC_W, 17, width of time-of-day and target registers; must satisfy 2^SEC_W >= DAY_SEC.

Ports:
- clk_int  in  1  system clock.
- rst_int  in  1  asynchronous, active-low reset.
- cfg_we  in  1  one-cycle write strobe for channel configuration.
- cfg_ch  in  4  channel index to write; writes with cfg_ch >= NUM_CH are ignored.
- cfg_en  in  1  channel enable value written.
- cfg_sec  in  SEC_W  target second-of-day written; values >= DAY_SEC are stored but never match.
- ack  in  NUM_CH  per-channel one-cycle acknowledge.
- stop_sw  in  1  level; while high, clears every channel in ALERT or SNOOZE.
- snooze  in  1  one-cycle pulse; moves all ALERT channels to SNOOZE.
- tod  out  SEC_W  current second of day.
- led  out  NUM_CH  bit i high while channel i is in ALERT.
- led_1pps  out  1  toggles on every second tick.
- cube  out  1  OR of led; registered.
- alarm_id  out  4  lowest-index channel in ALERT; 0 when none.

Behaviour:
- Reset (rst_int low, async): all counters 0; tod=0; all channels IDLE, en=0, target=0; led=0, led_1pps=0, cube=0, alarm_id=0.
- Prescaler: counts 0..TICK_DIV-1, wraps to 0; slot_tick is asserted in the cycle it wraps.
- Slot counter: advances on slot_tick, 0..SLOTS_PER_SEC-1. sec_tick is asserted when slot_tick occurs with the slot counter at SLOTS_PER_SEC-1. The first sec_tick follows reset by exactly TICK_DIV*SLOTS_PER_SEC cycles.
- On sec_tick: tod <= (tod==DAY_SEC-1) ? 0 : tod+1; led_1pps toggles.
- Per-channel FSM, states IDLE / ALERT / SNOOZE, with a per-channel snooze down-counter.
  - IDLE -> ALERT: sec_tick, en=1 and next tod value == target. Evaluated on the post-increment tod, so led rises in the same cycle tod shows the target.
  - ALERT -> IDLE: ack[i] high or stop_sw high.
  - ALERT -> SNOOZE: snooze pulse; counter loaded with SNOOZE_SEC.
  - SNOOZE: counter decrements on sec_tick. On the sec_tick where it equals 1 -> ALERT. stop_sw -> IDLE; ack[i] -> IDLE.
  - Alarm re-fires daily; a channel already in ALERT/SNOOZE ignores a new match.
- Priority within one cycle, highest first: cfg write to that channel > stop_sw > ack[i] > snooze > sec_tick events.
- cfg write: updates en and target and forces that channel to IDLE. Written values take effect for a match on the following cycle.
- Register timing: led, cube and alarm_id are registered from the FSM state. led and alarm_id update in the same cycle as the state change; cube lags led by 1 cycle.
- tod continues counting regardless of channel activity. Channels do not affect timing.

Test Plan (TICK_DIV=4, SLOTS_PER_SEC=2, DAY_SEC=10, SNOOZE_SEC=3, NUM_CH=4; 1 s = 8 cycles):
- Reset release -> first sec_tick at cycle 8; tod 0->1, led_1pps 0->1. After 80 cycles tod wraps 9->0 and led_1pps is back to 0.
- Write ch2 en=1 sec=3 -> led=4'b0100 when tod becomes 3; alarm_id=2; cube=1 one cycle later. ack[2] -> led=0, cube=0 next cycle.
- ch0 at sec=5 and ch3 at sec=5 -> led=4'b1001, alarm_id=0. ack[0] -> alarm_id=3.
- ch1 ALERT at tod=2, snooze pulse -> led=0; re-alerts at tod=5. stop_sw high at tod=4 instead -> stays IDLE at tod=5.
- cfg write to ch1 in the same cycle as ack[1] and its match -> ch1 IDLE with the new target. Writes with cfg_ch=7 leave all channels unchanged.
- Assert rst_int mid-ALERT -> led, cube, tod and led_1pps go to 0 immediately (async); all channels disabled.
